// File: rtl/sr_flip_flop.sv
// WIDTH independent clocked SR slices with a parameter-selected S=R=1 result.
// Define SR_ILLEGAL_DETECT_EN to add the both_seen / both_cnt S=R=1 monitors.
module sr_flip_flop #(
    parameter int              WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int              BOTH_POLICY = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] q
`ifdef SR_ILLEGAL_DETECT_EN
    ,
    output logic [WIDTH-1:0] both_seen,
    output logic [7:0]       both_cnt
`endif
);

    // Out-of-range policies fall back to hold.
    localparam int POLICY = (BOTH_POLICY < 0 || BOTH_POLICY > 3) ? 0 : BOTH_POLICY;

    logic [1:0]       sync_reg;
    logic             ready;
    logic [WIDTH-1:0] state_reg;
    logic [WIDTH-1:0] state_next;
    logic [WIDTH-1:0] both_hits;

    // Reset release passes through two flops before S/R are honoured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], 1'b1};
        end
    end

    assign ready     = sync_reg[1];
    assign both_hits = S & R;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_slice
            logic both_val;

            if (POLICY == 1) begin : g_set
                assign both_val = 1'b1;
            end else if (POLICY == 2) begin : g_rst
                assign both_val = 1'b0;
            end else if (POLICY == 3) begin : g_tgl
                assign both_val = ~state_reg[gi];
            end else begin : g_hold
                assign both_val = state_reg[gi];
            end

            always_comb begin
                state_next[gi] = state_reg[gi];
                case ({S[gi], R[gi]})
                    2'b10:   state_next[gi] = 1'b1;
                    2'b01:   state_next[gi] = 1'b0;
                    2'b11:   state_next[gi] = both_val;
                    default: state_next[gi] = state_reg[gi];
                endcase
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= RESET_VALUE;
        end else if (ready) begin
            state_reg <= state_next;
        end
    end

    // q is derived from the single stored bit, so Q==q can never occur.
    assign Q = state_reg;
    assign q = ~state_reg;

`ifdef SR_ILLEGAL_DETECT_EN
    logic [WIDTH-1:0] seen_reg;
    logic [7:0]       cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_reg <= '0;
            cnt_reg  <= 8'd0;
        end else if (ready) begin
            seen_reg <= seen_reg | both_hits;
            if ((|both_hits) && (cnt_reg != 8'hFF)) begin
                cnt_reg <= cnt_reg + 8'd1;
            end
        end
    end

    assign both_seen = seen_reg;
    assign both_cnt  = cnt_reg;
`else
    logic unused_hits;
    assign unused_hits = |both_hits;
`endif

endmodule

// File: tb/tb_sr_flip_flop.sv
// Directed bench for sr_flip_flop: one 2-bit hold-policy instance plus 1-bit
// instances for set-dominant, reset-dominant, toggle and an out-of-range policy.
module tb_sr_flip_flop;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] s_in;
    logic [1:0] r_in;
    logic [1:0] q0_t, q0_c;
    logic       q1_t, q1_c, q2_t, q2_c, q3_t, q3_c, q4_t, q4_c;
    int         checks = 0;
    int         passed = 0;
`ifdef SR_ILLEGAL_DETECT_EN
    logic [1:0] seen0;
    logic [7:0] cnt0;
    logic       seen1, seen2, seen3, seen4;
    logic [7:0] cnt1, cnt2, cnt3, cnt4;
`endif

    always #5 clk = ~clk;

    sr_flip_flop #(.WIDTH(2), .RESET_VALUE(2'b00), .BOTH_POLICY(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .S(s_in), .R(r_in), .Q(q0_t), .q(q0_c)
`ifdef SR_ILLEGAL_DETECT_EN
        , .both_seen(seen0), .both_cnt(cnt0)
`endif
    );
    sr_flip_flop #(.WIDTH(1), .RESET_VALUE(1'b0), .BOTH_POLICY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .S(s_in[0]), .R(r_in[0]), .Q(q1_t), .q(q1_c)
`ifdef SR_ILLEGAL_DETECT_EN
        , .both_seen(seen1), .both_cnt(cnt1)
`endif
    );
    sr_flip_flop #(.WIDTH(1), .RESET_VALUE(1'b0), .BOTH_POLICY(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .S(s_in[0]), .R(r_in[0]), .Q(q2_t), .q(q2_c)
`ifdef SR_ILLEGAL_DETECT_EN
        , .both_seen(seen2), .both_cnt(cnt2)
`endif
    );
    sr_flip_flop #(.WIDTH(1), .RESET_VALUE(1'b0), .BOTH_POLICY(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .S(s_in[0]), .R(r_in[0]), .Q(q3_t), .q(q3_c)
`ifdef SR_ILLEGAL_DETECT_EN
        , .both_seen(seen3), .both_cnt(cnt3)
`endif
    );
    sr_flip_flop #(.WIDTH(1), .RESET_VALUE(1'b0), .BOTH_POLICY(5)) dut4 (
        .clk(clk), .rst_n(rst_n), .S(s_in[0]), .R(r_in[0]), .Q(q4_t), .q(q4_c)
`ifdef SR_ILLEGAL_DETECT_EN
        , .both_seen(seen4), .both_cnt(cnt4)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input logic [1:0] s, input logic [1:0] r);
        s_in = s;
        r_in = r;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(2'b11, 2'b00);

        // Reset held: S ignored
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_Q", q0_t, 8'h0);
            chk("rst_q", q0_c, 8'h3);
        end

        // Release: two sync edges, sample on the third
        rst_n = 1'b1;
        tick();
        chk("sync1_Q", q0_t, 8'h0);
        tick();
        chk("sync2_Q", q0_t, 8'h0);
        tick();
        chk("first_sample_Q", q0_t, 8'h3);
        chk("first_sample_q", q0_c, 8'h0);

        // Set then hold
        drive(2'b00, 2'b00);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold1_Q", q0_t, 8'h3);
        end

        // Reset then hold
        drive(2'b00, 2'b11);
        tick();
        chk("clr_Q", q0_t, 8'h0);
        chk("clr_q", q0_c, 8'h3);
        drive(2'b00, 2'b00);
        tick();
        chk("hold0_Q", q0_t, 8'h0);

        // Independent slices
        drive(2'b01, 2'b10);
        tick();
        chk("indep_a_Q", q0_t, 8'h1);
        chk("indep_a_q", q0_c, 8'h2);
        drive(2'b10, 2'b01);
        tick();
        chk("indep_b_Q", q0_t, 8'h2);

        // Pulse between edges has no effect
        drive(2'b11, 2'b00);
        #3;
        drive(2'b00, 2'b00);
        tick();
        chk("pulse_Q", q0_t, 8'h2);

        // Both-high policies, starting from Q=1
        drive(2'b11, 2'b00);
        tick();
        chk("pre_both_Q0", q0_t, 8'h3);
        chk("pre_both_Q3", {7'd0, q3_t}, 8'h1);
        drive(2'b11, 2'b11);
        tick();
        chk("both_p0_Q", q0_t, 8'h3);
        chk("both_p1_Q", {7'd0, q1_t}, 8'h1);
        chk("both_p2_Q", {7'd0, q2_t}, 8'h0);
        chk("both_p2_q", {7'd0, q2_c}, 8'h1);
        chk("both_p3_Q_e1", {7'd0, q3_t}, 8'h0);
        chk("both_p3_q_e1", {7'd0, q3_c}, 8'h1);
        chk("both_p5_Q", {7'd0, q4_t}, 8'h1);
        tick();
        chk("both_p3_Q_e2", {7'd0, q3_t}, 8'h1);
        chk("both_p3_q_e2", {7'd0, q3_c}, 8'h0);
        chk("both_p0_Q_e2", q0_t, 8'h3);
        tick();
        chk("both_p3_Q_e3", {7'd0, q3_t}, 8'h0);

        // Sequence 10,01,11,00 under hold policy
        drive(2'b11, 2'b00);
        tick();
        chk("seq10_Q", q0_t, 8'h3);
        drive(2'b00, 2'b11);
        tick();
        chk("seq01_Q", q0_t, 8'h0);
        drive(2'b11, 2'b11);
        tick();
        chk("seq11_Q", q0_t, 8'h0);
        drive(2'b00, 2'b00);
        tick();
        chk("seq00_Q", q0_t, 8'h0);

        // Async reset mid-cycle
        drive(2'b11, 2'b00);
        tick();
        chk("pre_async_Q", q0_t, 8'h3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_Q", q0_t, 8'h0);
        chk("async_q", q0_c, 8'h3);
        chk("async_p3_Q", {7'd0, q3_t}, 8'h0);
        tick();
        chk("async_hold_Q", q0_t, 8'h0);

        rst_n = 1'b1;
        tick();
        tick();
`ifdef SR_ILLEGAL_DETECT_EN
        chk("seen_after_rst", {6'd0, seen0}, 8'h0);
        chk("cnt_after_rst", cnt0, 8'h0);
        drive(2'b11, 2'b11);
        tick();
        chk("cnt_first", cnt0, 8'h1);
        for (int i = 1; i < 300; i++) begin
            tick();
        end
        chk("seen_sat", {6'd0, seen0}, 8'h3);
        chk("cnt_sat", cnt0, 8'hFF);
        rst_n = 1'b0;
        #1;
        chk("seen_clr", {6'd0, seen0}, 8'h0);
        chk("cnt_clr", cnt0, 8'h0);
        rst_n = 1'b1;
`else
        tick();
        chk("resample_Q", q0_t, 8'h3);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
